// File: rtl/dwc_pcie_axi_eb_pkg.sv
// Shared types and helpers for the AXI channel elastic buffer.
// Optional feature macro: DWC_PCIE_AXI_EB_STALL_CNT_EN (stall counter port).
package dwc_pcie_axi_eb_pkg;

  localparam int EB_STALL_CNT_WD = 16;

  // Pointers are carried in 6 bits inside the helper, enough for DEPTH up to 64.
  localparam int EB_PTR_CARRY_WD = 6;

  // Wrapping increment: a FIFO of depth-1 entries wraps from depth-2 back to 0.
  function automatic logic [EB_PTR_CARRY_WD-1:0] eb_ptr_inc(input logic [EB_PTR_CARRY_WD-1:0] ptr,
                                                             input int depth);
    if (int'(ptr) >= depth - 2) return '0;
    else return ptr + 6'd1;
  endfunction

  // Width needed to count 0..depth inclusive.
  function automatic int eb_cnt_wd(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dwc_pcie_axi_eb_fifo_mem.sv
// Backing store behind the head register: DEPTH-1 entries, one write port,
// one asynchronous read port, wrapping pointers and an entry count.
module dwc_pcie_axi_eb_fifo_mem
  import dwc_pcie_axi_eb_pkg::*;
#(
  parameter int CHAN_WD = 3,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clrn,
  input  logic               wr_en,
  input  logic [CHAN_WD-1:0] wr_data,
  input  logic               rd_en,
  output logic [CHAN_WD-1:0] rd_data,
  output logic               empty
);

  localparam int FIFO_D = DEPTH - 1;
  localparam int PTR_WD = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_WD = eb_cnt_wd(FIFO_D);

  // Entries at or beyond FIFO_D are never addressed because the pointers wrap early.
  logic [CHAN_WD-1:0] mem [2**PTR_WD];
  logic [PTR_WD-1:0]  wr_ptr;
  logic [PTR_WD-1:0]  rd_ptr;
  logic [CNT_WD-1:0]  count;

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

  // Payload storage; contents need no reset since the pointers define what is live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and count bookkeeping; a simultaneous read and write leaves the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= PTR_WD'(eb_ptr_inc(EB_PTR_CARRY_WD'(wr_ptr), DEPTH));
      if (rd_en) rd_ptr <= PTR_WD'(eb_ptr_inc(EB_PTR_CARRY_WD'(rd_ptr), DEPTH));
      count <= count + CNT_WD'(wr_en) - CNT_WD'(rd_en);
    end
  end

endmodule

// File: rtl/dwc_pcie_axi_elastic_buf.sv
// DEPTH-entry order-preserving valid/ready elastic buffer for one AXI channel.
// Output valid/payload come straight from the head register; the remaining
// DEPTH-1 entries live in dwc_pcie_axi_eb_fifo_mem.
// Optional feature macro: DWC_PCIE_AXI_EB_STALL_CNT_EN adds a saturating
// stall_cnt output counting cycles with vld_to_dest & !rdy_from_dest.
module dwc_pcie_axi_elastic_buf
  import dwc_pcie_axi_eb_pkg::*;
#(
  parameter int CHAN_WD      = 3,
  parameter int DEPTH        = 2,
  parameter int P_FEED_READY = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clrn,
  input  logic                         vld_from_src,
  input  logic [CHAN_WD-1:0]           chanl_from_src,
  output logic                         rdy_to_src,
  output logic                         vld_to_dest,
  output logic [CHAN_WD-1:0]           chanl_to_dest,
  input  logic                         rdy_from_dest,
  output logic [eb_cnt_wd(DEPTH)-1:0]  occupancy
`ifdef DWC_PCIE_AXI_EB_STALL_CNT_EN
  ,
  output logic [EB_STALL_CNT_WD-1:0]   stall_cnt
`endif
);

  localparam int CNT_WD = eb_cnt_wd(DEPTH);

  typedef struct packed {
    logic               valid;
    logic [CHAN_WD-1:0] data;
  } eb_entry_t;

  eb_entry_t          head;
  logic               room;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               bypass;
  logic               fifo_wr;
  logic               fifo_rd;
  logic [CHAN_WD-1:0] fifo_rdata;

  assign room = (occupancy < CNT_WD'(DEPTH));

  // Feed-through mode lets a full buffer accept when the destination drains the head this cycle.
  if (P_FEED_READY != 0) begin : g_feed_ready
    assign rdy_to_src = room | rdy_from_dest;
  end else begin : g_flop_ready
    assign rdy_to_src = room;
  end

  assign vld_to_dest   = head.valid;
  assign chanl_to_dest = head.data;

  assign push = vld_from_src & rdy_to_src;
  assign pop  = vld_to_dest & rdy_from_dest;

  // A beat goes straight to the head only when nothing older waits in the FIFO.
  assign bypass  = push & fifo_empty & (~head.valid | pop);
  assign fifo_wr = push & ~bypass;
  assign fifo_rd = ~fifo_empty & (~head.valid | pop);

  dwc_pcie_axi_eb_fifo_mem #(
    .CHAN_WD (CHAN_WD),
    .DEPTH   (DEPTH)
  ) u_fifo_mem (
    .clk     (clk),
    .rstn    (rstn),
    .clrn    (clrn),
    .wr_en   (fifo_wr),
    .wr_data (chanl_from_src),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty)
  );

  // Head register: refill from the FIFO first, else bypass, else retire on pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
    end else if (!clrn) begin
      head <= '0;
    end else if (fifo_rd) begin
      head <= '{valid: 1'b1, data: fifo_rdata};
    end else if (bypass) begin
      head <= '{valid: 1'b1, data: chanl_from_src};
    end else if (pop) begin
      head.valid <= 1'b0;
    end
  end

  // Occupancy tracks every held beat including the head.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occupancy <= '0;
    end else if (!clrn) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + CNT_WD'(push) - CNT_WD'(pop);
    end
  end

`ifdef DWC_PCIE_AXI_EB_STALL_CNT_EN
  // Saturating count of cycles the destination back-pressures a valid beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (!clrn) begin
      stall_cnt <= '0;
    end else if (vld_to_dest && !rdy_from_dest && (stall_cnt != {EB_STALL_CNT_WD{1'b1}})) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dwc_pcie_axi_elastic_buf.sv
// Scoreboard bench for dwc_pcie_axi_elastic_buf. Two instances share the
// stimulus: inst[0] is DEPTH=4 with flop-only ready, inst[1] is DEPTH=2 with
// feed-through ready. Each instance keeps a queue of accepted beats as its
// reference model. Stall counter checks exist only when
// DWC_PCIE_AXI_EB_STALL_CNT_EN is defined.
module tb_dwc_pcie_axi_elastic_buf;

  localparam int CW = 8;

  logic          clk;
  logic          rstn;
  logic          clrn;
  logic          vld_from_src;
  logic [CW-1:0] chanl_from_src;
  logic          rdy_from_dest;

  logic          rdy_to_src    [2];
  logic          vld_to_dest   [2];
  logic [CW-1:0] chanl_to_dest [2];
  logic [2:0]    occupancy     [2];
`ifdef DWC_PCIE_AXI_EB_STALL_CNT_EN
  logic [15:0]   stall_cnt     [2];
`endif

  int checks = 0;
  int errors = 0;

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
  task automatic applyStimulus(input logic v, input logic [CW-1:0] d, input logic r, input logic c);
    vld_from_src   = v;
    chanl_from_src = d;
    rdy_from_dest  = r;
    clrn           = c;
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int DEP = (g == 0) ? 4 : 2;
    localparam int PFR = (g == 0) ? 0 : 1;

    logic [$clog2(DEP+1)-1:0] occ_l;
    logic [CW-1:0]            sb[$];

    assign occupancy[g] = 3'(occ_l);

    dwc_pcie_axi_elastic_buf #(
      .CHAN_WD      (CW),
      .DEPTH        (DEP),
      .P_FEED_READY (PFR)
    ) u_dut (
      .clk            (clk),
      .rstn           (rstn),
      .clrn           (clrn),
      .vld_from_src   (vld_from_src),
      .chanl_from_src (chanl_from_src),
      .rdy_to_src     (rdy_to_src[g]),
      .vld_to_dest    (vld_to_dest[g]),
      .chanl_to_dest  (chanl_to_dest[g]),
      .rdy_from_dest  (rdy_from_dest),
      .occupancy      (occ_l)
`ifdef DWC_PCIE_AXI_EB_STALL_CNT_EN
      ,
      .stall_cnt      (stall_cnt[g])
`endif
    );

    // Expected-beat recorder: late in the cycle, log each accepted beat; reset/clear flush everything.
    always @(negedge clk) begin
      #3;
      if (!rstn || !clrn) sb.delete();
      else if (vld_from_src && rdy_to_src[g]) sb.push_back(chanl_from_src);
    end

    // Monitor: compare visible state with the queue model and retire beats on handshake.
    always @(negedge clk) begin
      if (!rstn) begin
        checkOutput($sformatf("i%0d_rst_vld", g), 32'(vld_to_dest[g]), 32'd0);
        checkOutput($sformatf("i%0d_rst_occ", g), 32'(occupancy[g]), 32'd0);
        checkOutput($sformatf("i%0d_rst_data", g), 32'(chanl_to_dest[g]), 32'd0);
      end else begin
        checkOutput($sformatf("i%0d_occ", g), 32'(occupancy[g]), 32'(sb.size()));
        checkOutput($sformatf("i%0d_vld", g), 32'(vld_to_dest[g]), 32'(sb.size() != 0));
        checkOutput($sformatf("i%0d_rdy", g), 32'(rdy_to_src[g]),
                    32'((sb.size() < DEP) || ((PFR != 0) && rdy_from_dest)));
        if (vld_to_dest[g] && sb.size() != 0) begin
          checkOutput($sformatf("i%0d_data", g), 32'(chanl_to_dest[g]), 32'(sb[0]));
          if (rdy_from_dest) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rstn           = 1'b0;
    clrn           = 1'b1;
    vld_from_src   = 1'b0;
    chanl_from_src = '0;
    rdy_from_dest  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("reset_occ%0d", g), 32'(occupancy[g]), 32'd0);
      checkOutput($sformatf("reset_vld%0d", g), 32'(vld_to_dest[g]), 32'd0);
      checkOutput($sformatf("reset_data%0d", g), 32'(chanl_to_dest[g]), 32'd0);
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] fill DEPTH=4 with 1..4 under back-pressure");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, CW'(i), 1'b0, 1'b1);
    checkOutput("full_rdy", 32'(rdy_to_src[0]), 32'd0);
    checkOutput("full_occ", 32'(occupancy[0]), 32'd4);
    checkOutput("full_head", 32'(chanl_to_dest[0]), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("drain_order", 32'(chanl_to_dest[0]), 32'(i));
      checkOutput("drain_vld", 32'(vld_to_dest[0]), 32'd1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("drained_vld", 32'(vld_to_dest[0]), 32'd0);

    $display("[TB] bypass latency from empty");
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b1);
    checkOutput("bypass_vld", 32'(vld_to_dest[0]), 32'd1);
    checkOutput("bypass_data", 32'(chanl_to_dest[0]), 32'h05);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);

    $display("[TB] feed-through ready with full DEPTH=2");
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
    checkOutput("pfr_full_occ", 32'(occupancy[1]), 32'd2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, CW'(8'h20 + i), 1'b1, 1'b1);
      checkOutput("pfr_occ_steady", 32'(occupancy[1]), 32'd2);
    end
    repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    $display("[TB] synchronous clear with push and pop");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, CW'(8'h30 + i), 1'b0, 1'b1);
    checkOutput("pre_clr_occ", 32'(occupancy[0]), 32'd3);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    checkOutput("clr_occ", 32'(occupancy[0]), 32'd0);
    checkOutput("clr_vld", 32'(vld_to_dest[0]), 32'd0);
    checkOutput("clr_data", 32'(chanl_to_dest[0]), 32'd0);
    checkOutput("clr_occ_b", 32'(occupancy[1]), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] asynchronous reset mid-burst");
    applyStimulus(1'b1, 8'h40, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b1);
    checkOutput("pre_rst_occ", 32'(occupancy[0]), 32'd2);
    vld_from_src = 1'b0;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_vld", 32'(vld_to_dest[0]), 32'd0);
    checkOutput("async_rst_occ", 32'(occupancy[0]), 32'd0);
    checkOutput("async_rst_data", 32'(chanl_to_dest[0]), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    applyStimulus(1'b1, 8'h50, 1'b0, 1'b1);
    checkOutput("post_rst_vld", 32'(vld_to_dest[0]), 32'd1);
    checkOutput("post_rst_data", 32'(chanl_to_dest[0]), 32'h50);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), CW'($urandom), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 60) != 0));
    end
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("final_empty", 32'(occupancy[0]), 32'd0);

`ifdef DWC_PCIE_AXI_EB_STALL_CNT_EN
    $display("[TB] stall counter saturation");
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    vld_from_src = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    checkOutput("stall_sat", 32'(stall_cnt[0]), 32'hFFFF);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("stall_clr", 32'(stall_cnt[0]), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
